// File: rtl/edge_detector_array.sv
`default_nettype none
// ============================================================================
// Module   : edge_detector_array
// Purpose  : Multi-channel glitch-filtered edge detector with per-channel
//            edge mode, single-cycle pulse, sticky W1C pending flags and IRQ.
//            Optional saturating edge counters: EDGE_DETECTOR_ARRAY_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detector_array #(
    parameter int                NUM_CH        = 8,
    parameter int                CLK_DLY       = 0,
    parameter int                FILTER_CYCLES = 0,
    parameter logic [NUM_CH-1:0] INITIAL_LEVEL = '0
`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
    ,
    parameter int                COUNT_W       = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [NUM_CH-1:0]     in,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     clear,
    output logic [NUM_CH-1:0]     level,
    output logic [NUM_CH-1:0]     edge_detected,
    output logic [NUM_CH-1:0]     pending,
    output logic                  irq
`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
    ,
    output logic [NUM_CH*COUNT_W-1:0] edge_count
`endif
);

    localparam int               CNT_W   = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

    logic [NUM_CH-1:0] level_q, level_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic              irq_q, irq_d;

    // A level change is accepted once the differing run has lasted F+1 samples.
    always_comb begin
        level_d = level_q;
        accept  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (clk_en) begin
                if (in[c] == level_q[c]) begin
                    cnt_d[c] = '0;
                end else if (cnt_q[c] == CNT_MAX) begin
                    level_d[c] = in[c];
                    cnt_d[c]   = '0;
                    accept[c]  = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        qual = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            qual[c] = accept[c] & ((mode[2*c] & in[c]) | (mode[2*c+1] & ~in[c]));
        end
        // Set has priority over a coincident clear.
        pending_d = (pending_q & ~clear) | qual;
        irq_d     = |pending_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= INITIAL_LEVEL;
            pending_q <= '0;
            irq_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            level_q   <= level_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign level   = level_q;
    assign pending = pending_q;
    assign irq     = irq_q;

    generate
        if (CLK_DLY != 0) begin : g_dly
            logic [NUM_CH-1:0] pulse_q, pulse_d;

            always_comb begin
                pulse_d = qual;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pulse_q <= '0;
                end else begin
                    pulse_q <= pulse_d;
                end
            end

            assign edge_detected = pulse_q;
        end else begin : g_comb
            // The raw input can differ from the reset level, so mask explicitly.
            assign edge_detected = qual & {NUM_CH{~reset}};
        end
    endgenerate

`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
    logic [COUNT_W-1:0] count_q [NUM_CH];
    logic [COUNT_W-1:0] count_d [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            count_d[c] = count_q[c];
            if (clear[c]) begin
                count_d[c] = '0;
            end else if (qual[c] && (count_q[c] != {COUNT_W{1'b1}})) begin
                count_d[c] = count_q[c] + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c] <= count_d[c];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_count_out
            assign edge_count[g*COUNT_W +: COUNT_W] = count_q[g];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_detector_array
// Purpose  : Directed self-checking bench; three DUT configurations share one
//            stimulus set (F=0 comb, F=3 comb, F=0 registered pulse).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_detector_array;

    localparam int N = 8;

    logic           clk     = 1'b0;
    logic           reset   = 1'b0;
    logic           clk_en  = 1'b1;
    logic [N-1:0]   in_v    = '0;
    logic [2*N-1:0] mode_v  = 16'h5555;
    logic [N-1:0]   clear_v = '0;

    logic [N-1:0] lvl_a, ed_a, pend_a;
    logic         irq_a;
    logic [N-1:0] lvl_b, ed_b, pend_b;
    logic         irq_b;
    logic [N-1:0] lvl_c, ed_c, pend_c;
    logic         irq_c;
`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
    logic [N*8-1:0] cnt_a, cnt_b, cnt_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_detector_array #(.NUM_CH(N), .CLK_DLY(0), .FILTER_CYCLES(0)) u_f0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .in(in_v), .mode(mode_v),
        .clear(clear_v), .level(lvl_a), .edge_detected(ed_a), .pending(pend_a),
        .irq(irq_a)
`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
        , .edge_count(cnt_a)
`endif
    );

    edge_detector_array #(.NUM_CH(N), .CLK_DLY(0), .FILTER_CYCLES(3)) u_f3 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .in(in_v), .mode(mode_v),
        .clear(clear_v), .level(lvl_b), .edge_detected(ed_b), .pending(pend_b),
        .irq(irq_b)
`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
        , .edge_count(cnt_b)
`endif
    );

    edge_detector_array #(.NUM_CH(N), .CLK_DLY(1), .FILTER_CYCLES(0)) u_dly (
        .clk(clk), .reset(reset), .clk_en(clk_en), .in(in_v), .mode(mode_v),
        .clear(clear_v), .level(lvl_c), .edge_detected(ed_c), .pending(pend_c),
        .irq(irq_c)
`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
        , .edge_count(cnt_c)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_v    = '0;
        clear_v = '0;
        clk_en  = 1'b1;
        #2;
        reset   = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state; raw input differs from reset level but no pulse may escape.
        #1;
        reset = 1'b1;
        in_v  = 8'h01;
        tick();
        #2;
        check_eq("rst_ed_a",   ed_a,   0);
        check_eq("rst_ed_c",   ed_c,   0);
        check_eq("rst_lvl_a",  lvl_a,  0);
        check_eq("rst_pend_a", pend_a, 0);
        check_eq("rst_irq_a",  irq_a,  0);
        in_v  = '0;
        reset = 1'b0;
        tick();

        // Basic rising edge, F=0, comb pulse.
        in_v = 8'h01;
        #2;
        check_eq("rise_ed_same_cycle", ed_a, 8'h01);
        check_eq("rise_lvl_before", lvl_a, 0);
        tick();
        check_eq("rise_lvl_after",  lvl_a,  8'h01);
        check_eq("rise_pend_after", pend_a, 8'h01);
        check_eq("rise_irq_after",  irq_a,  1);
        check_eq("rise_ed_gone",    ed_a,   0);

        // Glitch filter F=3: a 3-sample run is rejected, a 4-sample run accepted.
        do_reset();
        in_v = 8'h04;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq("f3_short_ed", ed_b, 0);
            tick();
        end
        in_v = 8'h00;
        tick();
        check_eq("f3_short_lvl", lvl_b, 0);
        in_v = 8'h04;
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq("f3_long_ed", ed_b, (i == 3) ? 8'h04 : 8'h00);
            tick();
        end
        check_eq("f3_long_lvl",  lvl_b,  8'h04);
        check_eq("f3_long_pend", pend_b, 8'h04);
        check_eq("f3_long_ed_after", ed_b, 0);

        // Registered pulse with sparse clk_en, falling mode on channel 1.
        do_reset();
        mode_v = 16'h5559;
        in_v   = 8'h02;
        tick();
        check_eq("dly_lvl_high", lvl_c, 8'h02);
        for (int k = 1; k <= 8; k++) begin
            clk_en = ((k % 4) == 0);
            in_v   = 8'h00;
            #2;
            check_eq("dly_ed", ed_c, (k == 5) ? 8'h02 : 8'h00);
            tick();
        end
        check_eq("dly_lvl_low", lvl_c,  0);
        check_eq("dly_pend",    pend_c, 8'h02);
        clk_en = 1'b1;
        mode_v = 16'h5555;

        // Pending: set wins over coincident clear; clear works without clk_en.
        do_reset();
        in_v = 8'h20;
        #2;
        check_eq("pend_ed1", ed_a, 8'h20);
        tick();
        check_eq("pend_set", pend_a, 8'h20);
        in_v = 8'h00;
        tick();
        in_v    = 8'h20;
        clear_v = 8'h20;
        #2;
        check_eq("pend_ed2", ed_a, 8'h20);
        tick();
        check_eq("pend_set_wins", pend_a, 8'h20);
        check_eq("pend_irq_held", irq_a,  1);
        clk_en = 1'b0;
        tick();
        check_eq("pend_cleared", pend_a, 0);
        check_eq("pend_irq_low", irq_a,  0);
        clear_v = '0;
        clk_en  = 1'b1;

        // Mode 11: every toggle pulses; mode 00: level tracks, no pulses.
        do_reset();
        mode_v = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            in_v[7] = ~in_v[7];
            #2;
            check_eq("both_ed", ed_a, 8'h80);
            tick();
        end
        check_eq("both_pend", pend_a, 8'h80);
        mode_v = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            in_v[7] = ~in_v[7];
            #2;
            check_eq("off_ed", ed_a, 0);
            tick();
            check_eq("off_lvl", lvl_a, {24'h0, in_v});
        end
        check_eq("off_pend", pend_a, 8'h80);

        // Asynchronous reset mid-filter, then the F=3 count restarts from 0.
        mode_v = 16'h5555;
        in_v   = 8'h84;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_lvl_a",  lvl_a,  0);
        check_eq("mid_rst_pend_a", pend_a, 0);
        check_eq("mid_rst_irq_a",  irq_a,  0);
        check_eq("mid_rst_ed_a",   ed_a,   0);
        check_eq("mid_rst_lvl_b",  lvl_b,  0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("mid_rst_f3_ed", ed_b, (i == 3) ? 8'h84 : 8'h00);
            tick();
        end
        check_eq("mid_rst_f3_lvl", lvl_b, 8'h84);

`ifdef EDGE_DETECTOR_ARRAY_COUNT_EN
        // 300 rising edges saturate an 8-bit counter; clear beats increment.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_v[0] = ~in_v[0];
            tick();
            if (i == 199) check_eq("cnt_100", cnt_a[7:0], 100);
        end
        check_eq("cnt_sat", cnt_a[7:0], 255);
        in_v[0] = 1'b1;
        clear_v = 8'h01;
        tick();
        check_eq("cnt_clear_wins", cnt_a[7:0], 0);
        clear_v = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_detector_array.md
Name: edge_detector_array

Overview:
Multi-channel, parametrised edge detector for the sound/OPL3 control path and SoC status lines. Per channel: digital glitch filter, run-time edge-mode select (off/rise/fall/both), single-cycle edge pulse, and a sticky pending flag with write-1-to-clear. Replaces ad-hoc per-signal edge detectors. Feeds timer-overflow and IRQ aggregation logic.

Parameters:
NUM_CH, 8, number of independent channels (1..32).
CLK_DLY, 0, 0 = combinational pulse in the accepting clk_en cycle; 1 = registered pulse one clk later.
FILTER_CYCLES, 0, F: a level change is accepted on the (F+1)th consecutive clk_en sample that differs from the filtered level; 0 = no filtering.
INITIAL_LEVEL, {NUM_CH{1'b0}}, NUM_CH-bit reset value of the filtered levels.
COUNT_W, 8, width of each edge counter; used only with the optional feature.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
clk_en  in  1  sample enable; all filter, level and flag updates occur only when high.
in  in  NUM_CH  raw inputs, synchronous to clk.
mode  in  2*NUM_CH  per-channel mode [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
clear  in  NUM_CH  write-1-to-clear mask for pending.
level  out  NUM_CH  filtered level, registered.
edge_detected  out  NUM_CH  single-cycle qualified edge pulse.
pending  out  NUM_CH  sticky edge flags.
irq  out  1  OR of pending, registered.

Behaviour:
- Reset (async, active-high): level=INITIAL_LEVEL, filter counters=0, pending=0, irq=0, registered pulses=0. While reset is high, edge_detected=0 in both CLK_DLY modes.
- Filter per channel, counter cnt of width clog2(F+1), minimum 1. On clk_en:
  - in==level: cnt<=0.
  - in!=level and cnt==F: level<=in, cnt<=0, accept=1.
  - Otherwise cnt<=cnt+1.
- Without clk_en: nothing changes.
- A differing run broken by one matching sample restarts from 0.
- F=0: level follows in on every clk_en, which is the classic single-register detector.
- qual = accept and one of:
  - rising: mode bit0 and new level 1.
  - falling: mode bit1 and new level 0.
- CLK_DLY=0: edge_detected = qual, combinational in the accepting cycle. The pulse is already gated by clk_en.
- CLK_DLY=1: edge_detected is qual registered. It is high exactly one clk after the accepting cycle, for one clk, independent of the next clk_en.
- Mode is sampled in the accepting cycle only. Mode 00 still tracks level with no pulse or flag. Changing mode mid-filter does not reset cnt.
- pending[c] is set on qual[c] and cleared on clear[c]. If set and clear coincide, set wins. Clear takes effect regardless of clk_en.
- irq <= |pending_next, so irq follows pending by 0 cycles (registered together).
- Channels are fully independent. Simultaneous edges on all channels are all reported.

Optional Feature:
Macro EDGE_DETECTOR_ARRAY_COUNT_EN.
- Defined: adds output edge_count, width NUM_CH*COUNT_W. Per-channel counter increments on qual, saturates at all-ones, and resets to 0 on reset or on clear[c]. Clear wins over a simultaneous increment.
- Undefined: port and counters absent; no other behaviour changes.

Test Plan:
- Reset, NUM_CH=8, F=0, CLK_DLY=0, mode=all 01, clk_en=1, in[0] 0->1 -> edge_detected[0]=1 in the same cycle only; level[0]=1 and pending[0]=1 next clk; irq=1.
- F=3, in[2] held 1 for 3 clk_en samples then dropped -> no level change, no pulse. Held for 4 samples -> level[2]=1, one pulse on the 4th sample.
- clk_en toggling 1-in-4, CLK_DLY=1, mode[1]=10, in[1] 1->0 -> pulse exactly one clk after the enabled sample, width 1 clk.
- pending[5] set; clear[5]=1 asserted in the same cycle as a new qual[5] -> pending[5] stays 1. Next cycle clear[5]=1 alone -> pending[5]=0, irq=0.
- mode=11, in[7] toggles every clk_en with F=0 -> pulse every sample. Mode 00 -> level toggles, no pulses, pending unchanged.
- Assert reset mid-filter (cnt=2) -> all outputs reset immediately. With COUNT_EN, 300 rising edges with COUNT_W=8 -> edge_count saturates at 255.
